// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
//   Timing generator for a parallel-RGB LCD panel. It divides clk down to a
//   pixel clock-enable, walks the H/V raster and produces registered sync,
//   display-enable and pixel coordinates. Scanning starts and stops only on
//   frame boundaries, so the panel never sees a partial frame. A free-running
//   PWM drives the backlight while the display is running.
//
// Ports
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   enable           1 = run display, 0 = stop at the end of the current frame
//   backlight_level  backlight duty in 1/2^PWM_WIDTH units
//   pixel_ce         one-clk strobe every CLK_DIV clks (pixel advance)
//   hsync_n          horizontal sync, active low
//   vsync_n          vertical sync, active low
//   display_enable   pixel data valid
//   x, y             current horizontal / vertical count
//   line_start       one-clk pulse when h becomes 0 while running
//   frame_start      one-clk pulse when (h,v) becomes (0,0) while running
//   running          high while scanning (including the draining last frame)
//   backlight        PWM backlight drive
// ---------------------------------------------------------------------------
module lcd_timing_gen #(
  parameter int CLK_DIV   = 5,
  parameter int H_ACTIVE  = 480,
  parameter int H_FRONT   = 5,
  parameter int H_SYNC    = 1,
  parameter int H_BACK    = 39,
  parameter int V_ACTIVE  = 272,
  parameter int V_FRONT   = 8,
  parameter int V_SYNC    = 1,
  parameter int V_BACK    = 7,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 9,
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] backlight_level,
  output logic                 pixel_ce,
  output logic                 hsync_n,
  output logic                 vsync_n,
  output logic                 display_enable,
  output logic [X_WIDTH-1:0]   x,
  output logic [Y_WIDTH-1:0]   y,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 running,
  output logic                 backlight
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_ACT    = X_WIDTH'(H_ACTIVE);
  localparam logic [X_WIDTH-1:0] HS_START = X_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [X_WIDTH-1:0] HS_END   = X_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_ACT    = Y_WIDTH'(V_ACTIVE);
  localparam logic [Y_WIDTH-1:0] VS_START = Y_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [Y_WIDTH-1:0] VS_END   = Y_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 pixel_ce_q, pixel_ce_d;
  logic [X_WIDTH-1:0]   h_q, h_d, h_step;
  logic [Y_WIDTH-1:0]   v_q, v_d, v_step;
  logic                 running_q, running_d;
  logic                 de_q, de_d;
  logic                 hsync_n_q, hsync_n_d;
  logic                 vsync_n_q, vsync_n_d;
  logic                 line_start_q, line_start_d;
  logic                 frame_start_q, frame_start_d;
  logic [PWM_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PWM_WIDTH-1:0] lvl_q, lvl_d;
  logic                 backlight_q, backlight_d;
  logic                 frame_end;
  logic                 vs_after_start, vs_before_end;

  always_comb begin
    // Pixel clock-enable: registered so it is glitch-free and aligned with
    // the counter updates it gates.
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pixel_ce_d = (div_q == DIV_LAST);

    h_step    = (h_q == H_LAST) ? '0 : h_q + X_WIDTH'(1);
    v_step    = v_q;
    if (h_q == H_LAST) begin
      v_step = (v_q == V_LAST) ? '0 : v_q + Y_WIDTH'(1);
    end
    frame_end = (h_q == H_LAST) && (v_q == V_LAST);

    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        // Entering RUN on a pixel strobe makes (0,0) the first counted pixel.
        if (enable && pixel_ce_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pixel_ce_q) begin
          h_d = h_step;
          v_d = v_step;
        end
        if (!enable) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (enable) begin
          state_d = ST_RUN;
          if (pixel_ce_q) begin
            h_d = h_step;
            v_d = v_step;
          end
        end else if (pixel_ce_q) begin
          // Keep scanning until the last pixel of the frame has been shown.
          if (frame_end) begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
          end else begin
            h_d = h_step;
            v_d = v_step;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase

    // Outputs are decoded from the next-state counters so the registered
    // outputs line up with x/y in the same clk.
    running_d = (state_d != ST_IDLE);
    de_d      = running_d && (h_d < H_ACT) && (v_d < V_ACT);
    hsync_n_d = !(running_d && (h_d >= HS_START) && (h_d < HS_END));

    // vsync edges are placed on hsync falling edges, so the sync window is a
    // range of raster positions rather than a range of whole lines.
    vs_after_start = (v_d > VS_START) || ((v_d == VS_START) && (h_d >= HS_START));
    vs_before_end  = (v_d < VS_END)   || ((v_d == VS_END)   && (h_d <  HS_START));
    vsync_n_d      = !(running_d && vs_after_start && vs_before_end);

    line_start_d  = pixel_ce_q && running_d && (h_d == '0);
    frame_start_d = pixel_ce_q && running_d && (h_d == '0) && (v_d == '0);

    // Backlight PWM: the level is only picked up at the period wrap so a
    // mid-period change never produces a runt pulse.
    pcnt_d      = pcnt_q + PWM_WIDTH'(1);
    lvl_d       = (pcnt_q == '1) ? backlight_level : lvl_q;
    backlight_d = running_d && ((lvl_d == '1) || (pcnt_d < lvl_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      pixel_ce_q    <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      running_q     <= 1'b0;
      de_q          <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pcnt_q        <= '0;
      lvl_q         <= '0;
      backlight_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      pixel_ce_q    <= pixel_ce_d;
      h_q           <= h_d;
      v_q           <= v_d;
      running_q     <= running_d;
      de_q          <= de_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pcnt_q        <= pcnt_d;
      lvl_q         <= lvl_d;
      backlight_q   <= backlight_d;
    end
  end

  assign pixel_ce       = pixel_ce_q;
  assign hsync_n        = hsync_n_q;
  assign vsync_n        = vsync_n_q;
  assign display_enable = de_q;
  assign x              = h_q;
  assign y              = v_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;
  assign running        = running_q;
  assign backlight      = backlight_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing_gen
//   Directed + randomized bench for lcd_timing_gen using a small raster
//   (13 x 8 pixels, CLK_DIV=3) so whole frames fit in a short run. A
//   reference model tracks the raster as a single linear pixel position and
//   derives every expected output from it each clk.
// ---------------------------------------------------------------------------
module tb_lcd_timing_gen;

  localparam int CLK_DIV   = 3;
  localparam int H_ACTIVE  = 6;
  localparam int H_FRONT   = 2;
  localparam int H_SYNC    = 2;
  localparam int H_BACK    = 3;
  localparam int V_ACTIVE  = 4;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 1;
  localparam int X_WIDTH   = 4;
  localparam int Y_WIDTH   = 3;
  localparam int PWM_WIDTH = 8;

  localparam int HT        = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;   // 13
  localparam int VT        = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;   // 8
  localparam int FRAME     = HT * VT;                                // 104 pixels
  localparam int FRAME_CLK = FRAME * CLK_DIV;                        // 312 clk
  localparam int HSS       = H_ACTIVE + H_FRONT;                     // 8
  localparam int VSS       = V_ACTIVE + V_FRONT;                     // 5
  localparam int PER       = 1 << PWM_WIDTH;                         // 256

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b0;
  logic [PWM_WIDTH-1:0] backlight_level = '0;
  logic                 pixel_ce, hsync_n, vsync_n, display_enable;
  logic [X_WIDTH-1:0]   x;
  logic [Y_WIDTH-1:0]   y;
  logic                 line_start, frame_start, running, backlight;

  lcd_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
    .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .PWM_WIDTH(PWM_WIDTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .backlight_level(backlight_level),
    .pixel_ce(pixel_ce), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .display_enable(display_enable), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start), .running(running), .backlight(backlight)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: clk edges since reset, linear raster position, run/stop.
  int m_n      = 0;
  int m_pos    = 0;
  int m_lvl    = 0;
  bit m_run    = 1'b0;
  bit m_stop   = 1'b0;
  bit m_newpix = 1'b0;

  always @(posedge clk or negedge reset_n) begin : model
    bit pce_b;
    bit run_n;
    bit stop_n;
    bit np;
    int pos_n;
    if (!reset_n) begin
      m_n      <= 0;
      m_pos    <= 0;
      m_lvl    <= 0;
      m_run    <= 1'b0;
      m_stop   <= 1'b0;
      m_newpix <= 1'b0;
    end else begin
      pce_b  = (m_n > 0) && (m_n % CLK_DIV == 0);
      run_n  = m_run;
      stop_n = m_stop;
      pos_n  = m_pos;
      np     = 1'b0;
      if (!m_run) begin
        if (enable && pce_b) begin
          run_n  = 1'b1;
          stop_n = 1'b0;
          pos_n  = 0;
          np     = 1'b1;
        end
      end else if (m_stop && !enable && pce_b && (m_pos == FRAME - 1)) begin
        run_n  = 1'b0;
        stop_n = 1'b0;
        pos_n  = 0;
      end else begin
        if (pce_b) begin
          pos_n = (m_pos + 1) % FRAME;
          np    = 1'b1;
        end
        stop_n = !enable;
      end
      m_n      <= m_n + 1;
      m_run    <= run_n;
      m_stop   <= stop_n;
      m_pos    <= pos_n;
      m_newpix <= np;
      if ((m_n + 1) % PER == 0) m_lvl <= int'(backlight_level);
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  h, v, pc;
    bit  de, hs_low, vs_low, ls, fs, bl, pce;
    h      = m_run ? (m_pos % HT) : 0;
    v      = m_run ? (m_pos / HT) : 0;
    de     = m_run && (h < H_ACTIVE) && (v < V_ACTIVE);
    hs_low = m_run && (h >= HSS) && (h < HSS + H_SYNC);
    vs_low = m_run && (m_pos >= VSS * HT + HSS) && (m_pos < (VSS + V_SYNC) * HT + HSS);
    ls     = m_newpix && m_run && (h == 0);
    fs     = m_newpix && m_run && (m_pos == 0);
    pce    = (m_n > 0) && (m_n % CLK_DIV == 0);
    pc     = m_n % PER;
    bl     = m_run && ((m_lvl == PER - 1) || (pc < m_lvl));
    chk("pixel_ce",       32'(pixel_ce),       32'(pce));
    chk("x",              32'(x),              32'(h));
    chk("y",              32'(y),              32'(v));
    chk("running",        32'(running),        32'(m_run));
    chk("display_enable", 32'(display_enable), 32'(de));
    chk("hsync_n",        32'(hsync_n),        32'(!hs_low));
    chk("vsync_n",        32'(vsync_n),        32'(!vs_low));
    chk("line_start",     32'(line_start),     32'(ls));
    chk("frame_start",    32'(frame_start),    32'(fs));
    chk("backlight",      32'(backlight),      32'(bl));
  endtask

  // Observed-activity trackers for the directed period/duty measurements.
  int cyc = 0;
  int last_fs = -1;
  int fs_period = 0;
  int fs_cnt = 0, de_cnt = 0, bl_cnt = 0, pce_cnt = 0, hs_fall = 0;
  logic prev_hs = 1'b1;

  task automatic clear_counts();
    fs_cnt = 0; de_cnt = 0; bl_cnt = 0; pce_cnt = 0; hs_fall = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check_all();
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
        fs_cnt++;
      end
      if (display_enable === 1'b1) de_cnt++;
      if (backlight === 1'b1) bl_cnt++;
      if (pixel_ce === 1'b1) pce_cnt++;
      if (prev_hs === 1'b1 && hsync_n === 1'b0) hs_fall++;
      prev_hs = hsync_n;
    end
  endtask

  task automatic wait_xy(input string tag, input int tx, input int ty, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (int'(x) == tx && int'(y) == ty) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_fs(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hsync_n"},  32'(hsync_n),        32'd1);
    chk({tag, "_vsync_n"},  32'(vsync_n),        32'd1);
    chk({tag, "_de"},       32'(display_enable), 32'd0);
    chk({tag, "_running"},  32'(running),        32'd0);
    chk({tag, "_backlight"},32'(backlight),      32'd0);
    chk({tag, "_pixel_ce"}, 32'(pixel_ce),       32'd0);
    chk({tag, "_x"},        32'(x),              32'd0);
    chk({tag, "_y"},        32'(y),              32'd0);
  endtask

  initial begin
    int cnt;
    int px, py;
    bit seen;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    backlight_level = 8'd64;
    reset_n = 1'b1;
    step(4);
    enable = 1'b1;

    // Steady-state raster: two whole frames after a frame_start.
    wait_fs("t1_first_fs", 2 * FRAME_CLK);
    clear_counts();
    step(2 * FRAME_CLK);
    chk("t1_fs_count",   32'(fs_cnt),    32'd2);
    chk("t1_fs_period",  32'(fs_period), 32'(FRAME_CLK));
    chk("t1_de_clks",    32'(de_cnt),    32'(2 * H_ACTIVE * V_ACTIVE * CLK_DIV));
    chk("t1_hsync_fall", 32'(hs_fall),   32'(2 * VT));
    chk("t1_pce_count",  32'(pce_cnt),   32'(2 * FRAME));

    // Asynchronous reset in the middle of an active line.
    wait_xy("t2_reach", 5, 2, 2 * FRAME_CLK);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    reset_n = 1'b1;
    last_fs = -1;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      cnt++;
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t2_restart_seen", 32'(seen), 32'd1);
    chk("t2_restart_clks", 32'(cnt),  32'd4);

    // Stop request mid-frame: the frame must finish at the last pixel.
    wait_xy("t3_reach_v2", 0, 2, 2 * FRAME_CLK);
    enable = 1'b0;
    seen = 1'b0;
    px = int'(x);
    py = int'(y);
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step(1);
      if (running === 1'b0) begin
        seen = 1'b1;
        break;
      end
      px = int'(x);
      py = int'(y);
    end
    chk("t3_stopped",     32'(seen), 32'd1);
    chk("t3_last_x",      32'(px),   32'(HT - 1));
    chk("t3_last_y",      32'(py),   32'(VT - 1));
    clear_counts();
    step(100);
    chk("t3_idle_hsync",  32'(hs_fall), 32'd0);
    chk("t3_idle_de",     32'(de_cnt),  32'd0);
    chk("t3_idle_fs",     32'(fs_cnt),  32'd0);

    // Restart, then a stop request withdrawn before the frame ends.
    enable = 1'b1;
    wait_fs("t3_restart_fs", FRAME_CLK);
    wait_xy("t3_reach_v1", 0, 1, 2 * FRAME_CLK);
    enable = 1'b0;
    wait_xy("t3_reach_v4", 0, 4, 2 * FRAME_CLK);
    enable = 1'b1;
    wait_fs("t3_resume_fs", 2 * FRAME_CLK);
    chk("t3_resume_period", 32'(fs_period), 32'(FRAME_CLK));

    // Backlight duty over a full PWM period with a settled level.
    backlight_level = 8'd64;
    step(2 * PER + 8);
    clear_counts();
    step(PER);
    chk("t4_duty64", 32'(bl_cnt), 32'd64);
    backlight_level = 8'd0;
    step(2 * PER + 8);
    clear_counts();
    step(PER);
    chk("t4_duty0", 32'(bl_cnt), 32'd0);
    backlight_level = 8'hFF;
    step(2 * PER + 8);
    clear_counts();
    step(PER);
    chk("t4_duty255", 32'(bl_cnt), 32'(PER));

    // Mid-period level change takes effect only after the wrap.
    backlight_level = 8'd64;
    step(2 * PER + 8);
    seen = 1'b0;
    for (int i = 0; i < PER + 4; i++) begin
      if (m_n % PER == 100) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    chk("t4_phase_found", 32'(seen), 32'd1);
    backlight_level = 8'd128;
    clear_counts();
    step(PER);
    chk("t4_duty_change", 32'(bl_cnt), 32'd101);

    // Randomized enable / level traffic with one random reset.
    for (int k = 0; k < 50; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      backlight_level = 8'($urandom);
      if (k == 25) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rndrst");
        step($urandom_range(1, 4));
        reset_n = 1'b1;
      end
      step($urandom_range(10, 90));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
